// File: rtl/lsu_out_demux.sv
// Store-side output register bank: decodes a store address to one of eight
// 32-bit registers and merges byte/half/word data into the addressed lanes.
module lsu_out_demux #(
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter int          SEL_LSB = 12,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_en,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_data_0,
  output logic [31:0] o_data_1,
  output logic [31:0] o_data_2,
  output logic [31:0] o_data_3,
  output logic [31:0] o_data_4,
  output logic [31:0] o_data_5,
  output logic [31:0] o_data_6,
  output logic [31:0] o_data_7,
  output logic [31:0] o_rd_data,
  output logic [7:0]  o_wr_pulse,
  output logic        o_misalign,
  output logic        o_err_sticky
);

  logic [31:0] regs [8];
  logic [2:0]  sel;
  logic        hit;
  logic        aligned;
  logic        commit;
  logic        reject;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;
  logic        unused_ok;

  // Only the base field, select field and the low two bits are decoded;
  // everything else in the address aliases.
  assign unused_ok = ^i_addr;

  always_comb begin
    sel       = i_addr[SEL_LSB+2:SEL_LSB];
    hit       = i_st_en && (i_addr[31:16] == BASE_HI);
    aligned   = 1'b0;
    lane_en   = 4'b0000;
    lane_data = i_st_data;
    case (i_st_size)
      2'b00: begin
        aligned   = 1'b1;
        lane_en   = 4'b0001 << i_addr[1:0];
        lane_data = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~i_addr[0];
        lane_en   = i_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{i_st_data[15:0]}};
      end
      2'b10: begin
        aligned   = (i_addr[1:0] == 2'b00);
        lane_en   = 4'b1111;
      end
      default: begin
        aligned   = 1'b0;
      end
    endcase
    commit = hit && aligned;
    reject = hit && !aligned;
  end

  // Data is replicated across lanes so a per-byte enable picks the right copy.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int n = 0; n < 8; n++) regs[n] <= RST_VAL;
      o_wr_pulse   <= 8'b0;
      o_misalign   <= 1'b0;
      o_err_sticky <= 1'b0;
    end else begin
      if (commit) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_en[b]) regs[sel][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
      o_wr_pulse <= commit ? (8'b0000_0001 << sel) : 8'b0;
      o_misalign <= reject;
      if (reject) o_err_sticky <= 1'b1;
    end
  end

  assign o_rd_data = regs[sel];
  assign o_data_0  = regs[0];
  assign o_data_1  = regs[1];
  assign o_data_2  = regs[2];
  assign o_data_3  = regs[3];
  assign o_data_4  = regs[4];
  assign o_data_5  = regs[5];
  assign o_data_6  = regs[6];
  assign o_data_7  = regs[7];

endmodule
